// File: rtl/adder_slice_sequencer.sv
// Digit-serial adder controller: drives one external 2-bit adder slice for
// WIDTH/2 cycles, least-significant digit first, feeding carry back each digit.
module adder_slice_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic [1:0]       slice_a,
   output logic [1:0]       slice_b,
   output logic             slice_cin,
   input  logic [1:0]       slice_sum,
   input  logic             slice_cout
);

   localparam int N  = WIDTH / 2;
   localparam int CW = (N < 2) ? 1 : $clog2(N + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t           state_r;
   state_t           state_next_s;
   logic [WIDTH-1:0] a_sh_r;
   logic [WIDTH-1:0] b_sh_r;
   logic [WIDTH-1:0] res_sh_r;
   logic [WIDTH-1:0] res_next_s;
   logic             carry_r;
   logic [CW-1:0]    cnt_r;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;

   // Next-state decode
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_next_s = RUN;
            end else begin
               state_next_s = IDLE;
            end
         end
         RUN: begin
            if (cnt_r == CNT_LAST) begin
               state_next_s = DONE;
            end else begin
               state_next_s = RUN;
            end
         end
         DONE:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // Slice drive depends only on state and registers, never on inputs
   always_comb begin
      slice_a   = 2'b00;
      slice_b   = 2'b00;
      slice_cin = 1'b0;
      if (state_r == RUN) begin
         slice_a   = a_sh_r[1:0];
         slice_b   = b_sh_r[1:0];
         slice_cin = carry_r;
      end else begin
         slice_a   = 2'b00;
         slice_b   = 2'b00;
         slice_cin = 1'b0;
      end
   end

   // New digit enters at the top of the result shift register
   always_comb begin
      res_next_s = (res_sh_r >> 2) | (WIDTH'(slice_sum) << (WIDTH - 2));
   end

   // State and registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         busy_r  <= (state_next_s == RUN) || (state_next_s == DONE);
         done_r  <= (state_next_s == DONE);
      end
   end

   // Operand/result datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh_r   <= {WIDTH{1'b0}};
         b_sh_r   <= {WIDTH{1'b0}};
         res_sh_r <= {WIDTH{1'b0}};
         carry_r  <= 1'b0;
         cnt_r    <= {CW{1'b0}};
         sum_r    <= {WIDTH{1'b0}};
         cout_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  a_sh_r   <= A;
                  b_sh_r   <= B;
                  carry_r  <= cin;
                  cnt_r    <= {CW{1'b0}};
                  res_sh_r <= {WIDTH{1'b0}};
               end
            end
            RUN: begin
               res_sh_r <= res_next_s;
               carry_r  <= slice_cout;
               a_sh_r   <= a_sh_r >> 2;
               b_sh_r   <= b_sh_r >> 2;
               cnt_r    <= cnt_r + CW'(1);
               if (cnt_r == CNT_LAST) begin
                  sum_r  <= res_next_s;
                  cout_r <= slice_cout;
               end
            end
            DONE: begin
               cnt_r <= cnt_r;
            end
            default: begin
               cnt_r <= {CW{1'b0}};
            end
         endcase
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign sum  = sum_r;
   assign cout = cout_r;

endmodule
